// File: rtl/tl45_decode_issue.sv
// tl45_decode_issue: decode/issue stage sitting directly after the fetch buffer.
// Splits the fetched word into fields, reads both regfile ports, builds operand B
// (register or extended immediate) and registers everything for execute. A
// 16-entry busy scoreboard holds back instructions whose sources are still
// in flight and back-pressures fetch while it does so.
module tl45_decode_issue #(
  // bit[op] set -> opcode op never writes rd (bit 0 covers NOP)
  parameter logic [31:0] NOWRITE_MASK = 32'h0000_0001
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  input  logic [31:0] i_buf_pc,
  input  logic [31:0] i_buf_inst,
  output logic [3:0]  o_rf_rs1_addr,
  output logic [3:0]  o_rf_rs2_addr,
  input  logic [31:0] i_rf_rs1_data,
  input  logic [31:0] i_rf_rs2_data,
  input  logic        i_wb_valid,
  input  logic [3:0]  i_wb_reg,
  output logic        o_dr_valid,
  output logic [31:0] o_dr_pc,
  output logic [4:0]  o_dr_opcode,
  output logic [3:0]  o_dr_rd,
  output logic        o_dr_wr,
  output logic [31:0] o_dr_sr1_val,
  output logic [31:0] o_dr_sr2_val
);

  // Immediate extension selected by the two mode bits.
  function automatic logic [31:0] extend_imm(input logic [1:0] mode, input logic [15:0] imm);
    logic [31:0] ext;
    case (mode)
      2'b00:   ext = {16'h0000, imm};
      2'b01:   ext = {{16{imm[15]}}, imm};
      2'b10:   ext = {imm, 16'h0000};
      2'b11:   ext = {{16{imm[15]}}, imm};
      default: ext = 32'h0000_0000;
    endcase
    return ext;
  endfunction

  // Decoded fields of the word currently offered by the fetch buffer
  logic [4:0]  op_s;
  logic        imm_flag_s;
  logic [1:0]  mode_s;
  logic [3:0]  rd_s;
  logic [3:0]  rs1_s;
  logic [3:0]  rs2_s;
  logic [15:0] imm16_s;
  logic [31:0] imm_ext_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic [31:0] sr2_s;
  logic        in_valid_s;
  logic        uses_rs2_s;
  logic        wr_s;

  // Scoreboard and hazard control
  logic [15:0] busy_r;
  logic [15:0] busy_next_s;
  logic [15:0] clr_mask_s;
  logic [15:0] set_mask_s;
  logic        hazard_s;
  logic        issue_s;

  // Regfile read addresses come straight from the fetched word.
  assign o_rf_rs1_addr = i_buf_inst[19:16];
  assign o_rf_rs2_addr = i_buf_inst[15:12];

  // Field split, r0 forcing and operand-B selection.
  always_comb begin
    op_s       = i_buf_inst[31:27];
    imm_flag_s = i_buf_inst[26];
    mode_s     = i_buf_inst[25:24];
    rd_s       = i_buf_inst[23:20];
    rs1_s      = i_buf_inst[19:16];
    rs2_s      = i_buf_inst[15:12];
    imm16_s    = i_buf_inst[15:0];
    imm_ext_s  = extend_imm(mode_s, imm16_s);
    in_valid_s = (i_buf_inst != 32'h0000_0000);
    uses_rs2_s = ~imm_flag_s;

    // r0 is hardwired to zero regardless of what the regfile returns
    if (rs1_s == 4'd0) begin
      rs1_val_s = 32'h0000_0000;
    end else begin
      rs1_val_s = i_rf_rs1_data;
    end

    if (rs2_s == 4'd0) begin
      rs2_val_s = 32'h0000_0000;
    end else begin
      rs2_val_s = i_rf_rs2_data;
    end

    if (imm_flag_s) begin
      sr2_s = imm_ext_s;
    end else begin
      sr2_s = rs2_val_s;
    end

    // A bubble has rd=0, so it can never claim a write
    wr_s = in_valid_s & (rd_s != 4'd0) & ~NOWRITE_MASK[op_s];
  end

  // RAW interlock against the scoreboard; r0 sources never interlock.
  always_comb begin
    hazard_s = in_valid_s &
               ((busy_r[rs1_s] & (rs1_s != 4'd0)) |
                (uses_rs2_s & busy_r[rs2_s] & (rs2_s != 4'd0)));
    issue_s  = ~i_pipe_stall & ~hazard_s;
  end

  assign o_pipe_stall = i_pipe_stall | hazard_s;

  // Next scoreboard: writeback clears, issue sets, set beats clear on the same reg.
  always_comb begin
    if (i_wb_valid && (i_wb_reg != 4'd0)) begin
      clr_mask_s = 16'd1 << i_wb_reg;
    end else begin
      clr_mask_s = 16'd0;
    end

    if (issue_s && wr_s) begin
      set_mask_s = 16'd1 << rd_s;
    end else begin
      set_mask_s = 16'd0;
    end

    if (i_pipe_flush) begin
      busy_next_s = 16'd0;
    end else begin
      busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_r <= 16'd0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Decode output register: flush > downstream stall > hazard bubble > issue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dr_valid   <= 1'b0;
      o_dr_pc      <= 32'h0000_0000;
      o_dr_opcode  <= 5'd0;
      o_dr_rd      <= 4'd0;
      o_dr_wr      <= 1'b0;
      o_dr_sr1_val <= 32'h0000_0000;
      o_dr_sr2_val <= 32'h0000_0000;
    end else if (i_pipe_flush || (!i_pipe_stall && hazard_s)) begin
      o_dr_valid   <= 1'b0;
      o_dr_pc      <= 32'h0000_0000;
      o_dr_opcode  <= 5'd0;
      o_dr_rd      <= 4'd0;
      o_dr_wr      <= 1'b0;
      o_dr_sr1_val <= 32'h0000_0000;
      o_dr_sr2_val <= 32'h0000_0000;
    end else if (i_pipe_stall) begin
      o_dr_valid   <= o_dr_valid;
      o_dr_pc      <= o_dr_pc;
      o_dr_opcode  <= o_dr_opcode;
      o_dr_rd      <= o_dr_rd;
      o_dr_wr      <= o_dr_wr;
      o_dr_sr1_val <= o_dr_sr1_val;
      o_dr_sr2_val <= o_dr_sr2_val;
    end else begin
      o_dr_valid   <= in_valid_s;
      o_dr_pc      <= i_buf_pc;
      o_dr_opcode  <= op_s;
      o_dr_rd      <= rd_s;
      o_dr_wr      <= wr_s;
      o_dr_sr1_val <= rs1_val_s;
      o_dr_sr2_val <= sr2_s;
    end
  end

endmodule

// File: tb/tb_tl45_decode_issue.sv
// Testbench for tl45_decode_issue: decode vector table, hand-written multi-cycle
// sequences, then randomized traffic against an abstract scoreboard model.
module tb_tl45_decode_issue;

  logic        clk;
  logic        rst_n;
  logic        pipe_stall_in;
  logic        pipe_flush;
  logic        pipe_stall_out;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic [3:0]  rf_rs1_addr;
  logic [3:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        dr_valid;
  logic [31:0] dr_pc;
  logic [4:0]  dr_opcode;
  logic [3:0]  dr_rd;
  logic        dr_wr;
  logic [31:0] dr_sr1_val;
  logic [31:0] dr_sr2_val;

  logic [31:0] rf [16];
  int total = 0;
  int bad   = 0;

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  tl45_decode_issue dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_pipe_stall  (pipe_stall_in),
    .i_pipe_flush  (pipe_flush),
    .o_pipe_stall  (pipe_stall_out),
    .i_buf_pc      (buf_pc),
    .i_buf_inst    (buf_inst),
    .o_rf_rs1_addr (rf_rs1_addr),
    .o_rf_rs2_addr (rf_rs2_addr),
    .i_rf_rs1_data (rf_rs1_data),
    .i_rf_rs2_data (rf_rs2_data),
    .i_wb_valid    (wb_valid),
    .i_wb_reg      (wb_reg),
    .o_dr_valid    (dr_valid),
    .o_dr_pc       (dr_pc),
    .o_dr_opcode   (dr_opcode),
    .o_dr_rd       (dr_rd),
    .o_dr_wr       (dr_wr),
    .o_dr_sr1_val  (dr_sr1_val),
    .o_dr_sr2_val  (dr_sr2_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        v;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic        w;
    logic [31:0] s1;
    logic [31:0] s2;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                         input logic [4:0] op, input logic [3:0] rd, input logic w,
                         input logic [31:0] s1, input logic [31:0] s2);
    chk({name, ".valid"}, {31'd0, dr_valid}, {31'd0, v});
    if (v) chk({name, ".pc"}, dr_pc, pc);
    chk({name, ".op"}, {27'd0, dr_opcode}, {27'd0, op});
    chk({name, ".rd"}, {28'd0, dr_rd}, {28'd0, rd});
    chk({name, ".wr"}, {31'd0, dr_wr}, {31'd0, w});
    chk({name, ".sr1"}, dr_sr1_val, s1);
    chk({name, ".sr2"}, dr_sr2_val, s2);
  endtask

  task automatic chk_zero(input string name);
    chk_out(name, 1'b0, 32'h0, 5'd0, 4'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic st,
                       input logic fl, input logic wv, input logic [3:0] wr);
    buf_inst      = inst;
    buf_pc        = pc;
    pipe_stall_in = st;
    pipe_flush    = fl;
    wb_valid      = wv;
    wb_reg        = wr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Reference operand-B immediate built from plain arithmetic
  function automatic logic [31:0] model_imm(input logic [31:0] inst);
    logic [31:0] u;
    logic [31:0] mode;
    u    = inst & 32'h0000_FFFF;
    mode = (inst >> 24) & 32'd3;
    if (mode == 32'd2) return u * 32'd65536;
    else if (mode == 32'd0) return u;
    else if (u >= 32'd32768) return u + 32'hFFFF_0000;
    else return u;
  endfunction

  logic [31:0] save_pc, save_s1, save_s2;

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'(i) * 32'h1111_1111;
    rf[0] = 32'hDEAD_BEEF;

    tbl[0] = '{32'h0811_1000, 32'h0000_0100, 1'b1, 5'd1,  4'd1,  1'b1, 32'h1111_1111, 32'h1111_1111};
    tbl[1] = '{32'h0D23_8001, 32'h0000_0104, 1'b1, 5'd1,  4'd2,  1'b1, 32'h3333_3333, 32'hFFFF_8001};
    tbl[2] = '{32'h0C23_8001, 32'h0000_0108, 1'b1, 5'd1,  4'd2,  1'b1, 32'h3333_3333, 32'h0000_8001};
    tbl[3] = '{32'h0E23_8001, 32'h0000_010C, 1'b1, 5'd1,  4'd2,  1'b1, 32'h3333_3333, 32'h8001_0000};
    tbl[4] = '{32'h0F23_8001, 32'h0000_0110, 1'b1, 5'd1,  4'd2,  1'b1, 32'h3333_3333, 32'hFFFF_8001};
    tbl[5] = '{32'h0051_2000, 32'h0000_0114, 1'b1, 5'd0,  4'd5,  1'b0, 32'h1111_1111, 32'h2222_2222};
    tbl[6] = '{32'h1000_0000, 32'h0000_0118, 1'b1, 5'd2,  4'd0,  1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{32'hFCF0_7FFF, 32'h0000_011C, 1'b1, 5'd31, 4'd15, 1'b1, 32'h0000_0000, 32'h0000_7FFF};

    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    chk_zero("reset_init");
    chk("reset_init.stall", {31'd0, pipe_stall_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: one decode per vector, scoreboard cleared by a flush in between
    for (int i = 0; i < 8; i++) begin
      do_flush();
      drive(tbl[i].inst, tbl[i].pc, 1'b0, 1'b0, 1'b0, 4'd0);
      chk($sformatf("tbl%0d.stall", i), {31'd0, pipe_stall_out}, 32'd0);
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].pc, tbl[i].op, tbl[i].rd,
              tbl[i].w, tbl[i].s1, tbl[i].s2);
    end

    // Reset mid-run: r1 made busy, then async reset clears outputs and scoreboard
    drive(32'h0811_1000, 32'h200, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    #2;
    rst_n = 1'b1;
    drive(32'h0811_1000, 32'h204, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("midreset.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("after_reset", 1'b1, 32'h204, 5'd1, 4'd1, 1'b1, rf[1], rf[1]);

    // RAW hazard: ADDI r1 then ADD reading r1
    do_flush();
    drive(32'h0D10_0001, 32'h300, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk_out("addi", 1'b1, 32'h300, 5'd1, 4'd1, 1'b1, 32'h0, 32'h1);
    for (int c = 0; c < 2; c++) begin
      drive(32'h0811_1000, 32'h304, 1'b0, 1'b0, 1'b0, 4'd0);
      chk($sformatf("raw_wait%0d.stall", c), {31'd0, pipe_stall_out}, 32'd1);
      step();
      chk_zero($sformatf("raw_wait%0d", c));
    end
    drive(32'h0811_1000, 32'h304, 1'b0, 1'b0, 1'b1, 4'd1);
    chk("raw_wbcycle.stall", {31'd0, pipe_stall_out}, 32'd1);
    step();
    chk_zero("raw_wbcycle");
    rf[1] = 32'h0000_0001;
    drive(32'h0811_1000, 32'h304, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("raw_release.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("raw_issue", 1'b1, 32'h304, 5'd1, 4'd1, 1'b1, 32'h1, 32'h1);

    // Downstream stall for 3 cycles with a WB of r1 in the middle
    do_flush();
    drive(32'h0811_1000, 32'h400, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    save_pc = 32'h400; save_s1 = rf[1]; save_s2 = rf[1];
    for (int c = 0; c < 3; c++) begin
      drive(32'h1022_2000, 32'h404, 1'b1, 1'b0, (c == 1), 4'd1);
      chk($sformatf("stall%0d.stall", c), {31'd0, pipe_stall_out}, 32'd1);
      step();
      chk_out($sformatf("stall%0d", c), 1'b1, save_pc, 5'd1, 4'd1, 1'b1, save_s1, save_s2);
    end
    drive(32'h1832_2000, 32'h408, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("stall_noset.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("stall_noset", 1'b1, 32'h408, 5'd3, 4'd3, 1'b1, rf[2], rf[2]);
    drive(32'h2041_1000, 32'h40C, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("stall_wbclr.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("stall_wbclr", 1'b1, 32'h40C, 5'd4, 4'd4, 1'b1, rf[1], rf[1]);

    // Flush with r1, r5 busy and a hazard pending
    do_flush();
    drive(32'h0811_1000, 32'h500, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(32'h0850_0000, 32'h504, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(32'h0865_1000, 32'h508, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("flush_pre.stall", {31'd0, pipe_stall_out}, 32'd1);
    drive(32'h0865_1000, 32'h508, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    chk_zero("flush");
    drive(32'h0865_1000, 32'h508, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("flush_post.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("flush_post", 1'b1, 32'h508, 5'd1, 4'd6, 1'b1, rf[5], rf[1]);

    // Same-edge set and clear of r3: set wins
    do_flush();
    drive(32'h0830_0000, 32'h600, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    drive(32'h0830_0000, 32'h604, 1'b0, 1'b0, 1'b1, 4'd3);
    step();
    drive(32'h0843_3000, 32'h608, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("setwins.stall", {31'd0, pipe_stall_out}, 32'd1);

    // r0 writer in flight, then a reader of r0 through rs2
    do_flush();
    drive(32'h0800_0000, 32'h700, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    chk_out("r0_writer", 1'b1, 32'h700, 5'd1, 4'd0, 1'b0, 32'h0, 32'h0);
    drive(32'h0854_0000, 32'h704, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("r0_reader.stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    chk_out("r0_reader", 1'b1, 32'h704, 5'd1, 4'd5, 1'b1, rf[4], 32'h0);

    // Randomized traffic against an abstract scoreboard model
    do_flush();
    begin
      bit          mbusy [16];
      logic        e_v, e_w;
      logic [31:0] e_pc, e_s1, e_s2;
      logic [4:0]  e_op;
      logic [3:0]  e_rd;
      for (int r = 0; r < 16; r++) mbusy[r] = 1'b0;
      e_v = 1'b0; e_w = 1'b0; e_pc = 32'h0; e_s1 = 32'h0; e_s2 = 32'h0;
      e_op = 5'd0; e_rd = 4'd0;
      for (int n = 0; n < 400; n++) begin
        logic [31:0] inst, pc;
        logic        st, fl, wv, hz, immf, wr;
        logic [3:0]  wrg;
        int          op, rd, rs1, rs2;
        logic [31:0] v1, v2;
        inst = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFF77_7FFF);
        pc   = $urandom;
        st   = ($urandom_range(0, 4) == 0);
        fl   = ($urandom_range(0, 19) == 0);
        wv   = ($urandom_range(0, 2) == 0);
        wrg  = 4'($urandom_range(0, 7));
        op   = int'(inst >> 27);
        rd   = int'((inst >> 20) & 32'hF);
        rs1  = int'((inst >> 16) & 32'hF);
        rs2  = int'((inst >> 12) & 32'hF);
        immf = inst[26];
        hz   = (inst != 0) && ((mbusy[rs1] && rs1 != 0) || (!immf && mbusy[rs2] && rs2 != 0));
        wr   = (inst != 0) && (rd != 0) && (((32'h0000_0001 >> op) & 32'd1) == 32'd0);
        v1   = (rs1 == 0) ? 32'h0 : rf[rs1];
        v2   = immf ? model_imm(inst) : ((rs2 == 0) ? 32'h0 : rf[rs2]);
        drive(inst, pc, st, fl, wv, wrg);
        chk($sformatf("rnd%0d.stall", n), {31'd0, pipe_stall_out}, {31'd0, st | hz});
        step();
        if (fl) begin
          for (int r = 0; r < 16; r++) mbusy[r] = 1'b0;
          e_v = 1'b0; e_w = 1'b0; e_pc = 32'h0; e_s1 = 32'h0; e_s2 = 32'h0;
          e_op = 5'd0; e_rd = 4'd0;
        end else begin
          if (wv && wrg != 4'd0) mbusy[wrg] = 1'b0;
          if (!st && hz) begin
            e_v = 1'b0; e_w = 1'b0; e_pc = 32'h0; e_s1 = 32'h0; e_s2 = 32'h0;
            e_op = 5'd0; e_rd = 4'd0;
          end else if (!st) begin
            e_v = (inst != 0); e_w = wr; e_pc = pc; e_s1 = v1; e_s2 = v2;
            e_op = 5'(op); e_rd = 4'(rd);
            if (wr) mbusy[rd] = 1'b1;
          end
        end
        if (wv && wrg != 4'd0) rf[wrg] = $urandom;
        chk_out($sformatf("rnd%0d", n), e_v, e_pc, e_op, e_rd, e_w, e_s1, e_s2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
